// File: rtl/gpu_pkg.sv
// Shared constants and the arbiter state type for the GPU shared-memory block.
package gpu_pkg;

  localparam int SM_ADDR_W = 12;
  localparam int SM_DATA_W = 8;
  localparam int N_CORES   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sm_arb_state_t;

endpackage

// File: rtl/sm_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_pick #(
  parameter int N_CORES = 16,
  parameter int ID_W    = $clog2(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W-1:0] idx;

  // Scan last_grant+1 .. last_grant+N_CORES; last_grant itself comes last.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= N_CORES; i++) begin
      idx = ID_W'((int'(last_grant) + i) % N_CORES);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/sm_arbiter.sv
// Round-robin arbiter sharing one single-port memory between N_CORES cores.
//
//  state | meaning
//  IDLE  | waiting for any req; picks winner and latches its command
//  ISSUE | sm_en strobe for the latched command
//  WAIT  | counting down memory latency; captures load data on terminal count
//  RESP  | val_data pulse to winner; winner becomes lowest priority
module sm_arbiter #(
  parameter int  N_CORES = gpu_pkg::N_CORES,
  parameter int  ADDR_W  = gpu_pkg::SM_ADDR_W,
  parameter int  DATA_W  = gpu_pkg::SM_DATA_W,
  parameter int  MEM_LAT = 1,
  localparam int ID_W    = $clog2(N_CORES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CORES-1:0]    req,
  input  logic [N_CORES-1:0]    we,
  input  logic [N_CORES*ADDR_W-1:0] addr,
  input  logic [N_CORES*DATA_W-1:0] wdata,
  output logic [N_CORES-1:0]    val_data,
  output logic [DATA_W-1:0]     rdata,
  output logic                  sm_en,
  output logic                  sm_we,
  output logic [ADDR_W-1:0]     sm_addr,
  output logic [DATA_W-1:0]     sm_wdata,
  input  logic [DATA_W-1:0]     sm_rdata,
  output logic                  busy,
  output logic [ID_W-1:0]       grant_id
);

  import gpu_pkg::*;

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_ISSUE = 2'(ISSUE);
  localparam logic [1:0] S_WAIT  = 2'(WAIT);
  localparam logic [1:0] S_RESP  = 2'(RESP);

  localparam int              CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]          state;
  logic [CNT_W-1:0]    wait_cnt;
  logic [ID_W-1:0]     last_grant;
  logic                pick_any;
  logic [ID_W-1:0]     pick_id;
  logic [N_CORES-1:0]  grant_onehot;
  logic [ADDR_W-1:0]   addr_arr  [N_CORES];
  logic [DATA_W-1:0]   wdata_arr [N_CORES];

  for (genvar k = 0; k < N_CORES; k++) begin : g_unpack
    assign addr_arr[k]  = addr[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = wdata[k*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_CORES (N_CORES),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_id)
  );

  // One-hot ack pattern for the current winner.
  always_comb begin
    grant_onehot           = '0;
    grant_onehot[grant_id] = 1'b1;
  end

  // Transaction FSM; the sm_* registers double as the latched command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      last_grant <= ID_W'(N_CORES - 1);
      grant_id   <= '0;
      val_data   <= '0;
      rdata      <= '0;
      sm_en      <= 1'b0;
      sm_we      <= 1'b0;
      sm_addr    <= '0;
      sm_wdata   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            grant_id <= pick_id;
            sm_en    <= 1'b1;
            sm_we    <= we[pick_id];
            sm_addr  <= addr_arr[pick_id];
            sm_wdata <= wdata_arr[pick_id];
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          sm_en    <= 1'b0;
          wait_cnt <= CNT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == CNT_ONE) begin
            if (!sm_we) rdata <= sm_rdata;
            val_data <= grant_onehot;
            state    <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end
        end
        S_RESP: begin
          val_data   <= '0;
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_arbiter.sv
// Directed + randomized bench for sm_arbiter with a transaction-level reference model.
module tb_sm_arbiter;

  localparam int N  = 16;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int L1 = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic [N-1:0]    req_v = '0;
  logic [N-1:0]    we_v  = '0;
  logic [N-1:0]    req3  = '0;
  logic [AW-1:0]   a_v [N];
  logic [DW-1:0]   d_v [N];
  logic [N*AW-1:0] addr_f;
  logic [N*DW-1:0] wdata_f;

  logic [N-1:0]  val_data, val_data3;
  logic [DW-1:0] rdata, rdata3, sm_wdata, sm_wdata3, sm_rdata, sm_rdata3;
  logic [AW-1:0] sm_addr, sm_addr3;
  logic          sm_en, sm_en3, sm_we, sm_we3, busy, busy3;
  logic [3:0]    grant_id, grant_id3;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign addr_f[k*AW +: AW]  = a_v[k];
    assign wdata_f[k*DW +: DW] = d_v[k];
  end

  sm_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .req(req_v), .we(we_v), .addr(addr_f), .wdata(wdata_f),
    .val_data(val_data), .rdata(rdata), .sm_en(sm_en), .sm_we(sm_we), .sm_addr(sm_addr),
    .sm_wdata(sm_wdata), .sm_rdata(sm_rdata), .busy(busy), .grant_id(grant_id));

  sm_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .req(req3), .we(we_v), .addr(addr_f), .wdata(wdata_f),
    .val_data(val_data3), .rdata(rdata3), .sm_en(sm_en3), .sm_we(sm_we3), .sm_addr(sm_addr3),
    .sm_wdata(sm_wdata3), .sm_rdata(sm_rdata3), .busy(busy3), .grant_id(grant_id3));

  always #5 clk = ~clk;

  function automatic logic [7:0] init_f(input logic [11:0] a);
    return a[7:0] ^ 8'hF9;
  endfunction

  // Memory macro models: unwritten locations read init_f(addr); idle read ports return noise.
  logic [7:0] mem1 [4096];
  bit         wf1  [4096];
  logic [7:0] mem3 [4096];
  bit         wf3  [4096];
  logic [7:0] p3_0, p3_1, p3_2;

  // Latency-1 memory for u1.
  always @(posedge clk) begin
    if (sm_en && sm_we) begin
      mem1[sm_addr] <= sm_wdata;
      wf1[sm_addr]  <= 1'b1;
    end
    sm_rdata <= (sm_en && !sm_we) ? (wf1[sm_addr] ? mem1[sm_addr] : init_f(sm_addr)) : 8'($urandom);
  end

  // Latency-3 memory for u3.
  always @(posedge clk) begin
    if (sm_en3 && sm_we3) begin
      mem3[sm_addr3] <= sm_wdata3;
      wf3[sm_addr3]  <= 1'b1;
    end
    p3_0 <= (sm_en3 && !sm_we3) ? (wf3[sm_addr3] ? mem3[sm_addr3] : init_f(sm_addr3)) : 8'($urandom);
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign sm_rdata3 = p3_2;

  int total = 0;
  int bad   = 0;
  int ptr   = N - 1;
  logic [7:0] cur_rd = '0;
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] ref_rd(input logic [11:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_f(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_core(input int k);
    we_v[k] = 1'($urandom_range(0, 1));
    a_v[k]  = AW'($urandom_range(0, 15));
    d_v[k]  = DW'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    ptr    = N - 1;
    cur_rd = '0;
  endtask

  // One arbitration round on u1, starting with the DUT idle and req_v already set.
  task automatic txn(input bit keep, input bit drop_early, input bit scramble);
    int w;
    logic [7:0]  exp_rd, exp_wd;
    logic [11:0] a;
    bit st;
    w = -1;
    for (int i = 1; i <= N; i++)
      if (w < 0 && req_v[(ptr + i) % N]) w = (ptr + i) % N;
    if (w < 0) begin
      step();
      chk("idle_sm_en", 32'(sm_en), 0);
      chk("idle_busy", 32'(busy), 0);
      return;
    end
    a = a_v[w]; st = we_v[w]; exp_wd = d_v[w];
    if (st) begin
      ref_mem[int'(a)] = exp_wd;
      exp_rd = cur_rd;
    end else begin
      exp_rd = ref_rd(a);
    end
    step();
    chk("issue_sm_en", 32'(sm_en), 1);
    chk("issue_sm_we", 32'(sm_we), 32'(st));
    chk("issue_sm_addr", 32'(sm_addr), 32'(a));
    if (st) chk("issue_sm_wdata", 32'(sm_wdata), 32'(exp_wd));
    chk("issue_grant_id", 32'(grant_id), 32'(w));
    chk("issue_busy", 32'(busy), 1);
    chk("issue_val", 32'(val_data), 0);
    if (scramble) rnd_core(w);
    if (drop_early) req_v[w] = 1'b0;
    step();
    chk("wait_sm_en", 32'(sm_en), 0);
    chk("wait_val", 32'(val_data), 0);
    for (int c = 1; c < L1; c++) step();
    step();
    chk("resp_val", 32'(val_data), 32'(1) << w);
    chk("resp_rdata", 32'(rdata), 32'(exp_rd));
    chk("resp_busy", 32'(busy), 1);
    cur_rd = exp_rd;
    ptr = w;
    if (keep) begin
      req_v[w] = 1'b1;
      rnd_core(w);
    end else begin
      req_v[w] = 1'b0;
    end
    step();
    chk("post_val", 32'(val_data), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  int en_c, val_c;
  logic [7:0]  rd_at, rd_got;
  logic [15:0] vd;

  initial begin
    for (int k = 0; k < N; k++) begin
      a_v[k] = '0;
      d_v[k] = '0;
    end
    step();
    step();
    chk("rst_val", 32'(val_data), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_sm_en", 32'(sm_en), 0);
    chk("rst_sm_we", 32'(sm_we), 0);
    chk("rst_sm_addr", 32'(sm_addr), 0);
    chk("rst_sm_wdata", 32'(sm_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy3", 32'(busy3), 0);
    reset = 1'b1;

    // Single load, single store, readback.
    a_v[3] = 12'h0A5; we_v[3] = 1'b0; req_v[3] = 1'b1;
    txn(0, 0, 0);
    a_v[0] = 12'hFFF; we_v[0] = 1'b1; d_v[0] = 8'h81; req_v[0] = 1'b1;
    txn(0, 0, 0);
    a_v[5] = 12'hFFF; we_v[5] = 1'b0; req_v[5] = 1'b1;
    txn(0, 0, 0);

    // Fairness: everybody requesting continuously from reset.
    do_reset();
    for (int k = 0; k < N; k++) rnd_core(k);
    req_v = '1;
    for (int i = 0; i < N + 1; i++) txn(1, 0, 0);
    req_v = '0;

    // Wrap around the priority pointer.
    we_v[15] = 1'b0; a_v[15] = 12'h010; req_v[15] = 1'b1;
    txn(0, 0, 0);
    rnd_core(2); rnd_core(14);
    req_v[2] = 1'b1; req_v[14] = 1'b1;
    txn(0, 0, 0);
    txn(0, 0, 0);

    // Reset during WAIT of a store from core 9 after core 8 was the last winner.
    we_v[8] = 1'b0; a_v[8] = 12'h020; req_v[8] = 1'b1;
    txn(0, 0, 0);
    a_v[9] = 12'h123; we_v[9] = 1'b1; d_v[9] = 8'h77; req_v[9] = 1'b1;
    step();
    chk("abort_issue_en", 32'(sm_en), 1);
    chk("abort_issue_grant", 32'(grant_id), 9);
    step();
    chk("abort_wait_busy", 32'(busy), 1);
    a_v[7] = 12'h123; we_v[7] = 1'b0; req_v[7] = 1'b1;
    reset = 1'b0;
    #1;
    chk("abort_val", 32'(val_data), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sm_en", 32'(sm_en), 0);
    chk("abort_sm_addr", 32'(sm_addr), 0);
    chk("abort_grant", 32'(grant_id), 0);
    chk("abort_rdata", 32'(rdata), 0);
    step();
    chk("abort_hold_val", 32'(val_data), 0);
    reset = 1'b1;
    ref_mem[int'(12'h123)] = 8'h77;
    ptr = N - 1;
    cur_rd = '0;
    txn(0, 0, 0);
    txn(0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < N; k++)
        if (!req_v[k] && $urandom_range(0, 2) == 0) begin
          rnd_core(k);
          req_v[k] = 1'b1;
        end
      txn(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 20 && req_v != '0; i++) txn(0, 0, 0);
    txn(0, 0, 0);

    // Latency-3 instance.
    we_v[4] = 1'b0; a_v[4] = 12'h0B0; req3[4] = 1'b1;
    en_c = 0; val_c = 0; rd_at = '0; rd_got = '0; vd = '0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (sm_en3 && en_c == 0) en_c = n;
      if (en_c != 0 && n == en_c + 3) rd_at = sm_rdata3;
      if (val_data3 != '0 && val_c == 0) begin
        val_c  = n;
        vd     = val_data3;
        rd_got = rdata3;
        req3[4] = 1'b0;
      end
    end
    chk("lat3_en_cycle", 32'(en_c), 1);
    chk("lat3_val_cycle", 32'(val_c), 5);
    chk("lat3_val", 32'(vd), 32'h0010);
    chk("lat3_mem", 32'(rd_at), 32'(init_f(12'h0B0)));
    chk("lat3_rdata", 32'(rd_got), 32'(rd_at));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
